// File: rtl/req_chan_arb.sv
// Round-robin arbiter sharing one request-channel subordinate among NUM_MGR managers through a one-entry output register.
// Optional per-manager grant counters are enabled by defining REQ_ARB_STATS_EN.
module req_chan_arb #(
    parameter int NUM_MGR = 4,
    parameter int MGR_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_MGR-1:0]      m_a_valid,
    output logic [NUM_MGR-1:0]      m_a_ready,
    input  logic [4*NUM_MGR-1:0]    m_a_id,
    input  logic [32*NUM_MGR-1:0]   m_a_addr,
    input  logic [6*NUM_MGR-1:0]    m_a_atop,
    output logic                    s_a_valid,
    input  logic                    s_a_ready,
    output logic [3:0]              s_a_id,
    output logic [31:0]             s_a_addr,
    output logic [5:0]              s_a_atop,
    output logic [MGR_W-1:0]        s_a_mgr
`ifdef REQ_ARB_STATS_EN
    ,
    input  logic                    stats_clr,
    output logic [16*NUM_MGR-1:0]   grant_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [MGR_W-1:0]  r_last;
    logic [3:0]        r_id;
    logic [31:0]       r_addr;
    logic [5:0]        r_atop;
    logic [MGR_W-1:0]  r_mgr;

    logic              w_can_load;
    logic              w_has_win;
    logic [MGR_W-1:0]  w_win;
    logic              w_accept;
    logic [3:0]        w_id;
    logic [31:0]       w_addr;
    logic [5:0]        w_atop;

    assign s_a_valid  = (r_state == FULL);
    assign s_a_id     = r_id;
    assign s_a_addr   = r_addr;
    assign s_a_atop   = r_atop;
    assign s_a_mgr    = r_mgr;
    assign w_can_load = ~s_a_valid | s_a_ready;
    assign w_accept   = w_can_load & w_has_win;

    // Search starts one past the last accepted manager and wraps at NUM_MGR.
    always_comb begin
        int unsigned idx;
        w_has_win = 1'b0;
        w_win     = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_MGR; k++) begin
            idx = (32'(r_last) + 1 + k) % NUM_MGR;
            for (int unsigned i = 0; i < NUM_MGR; i++) begin
                if (!w_has_win && (i == idx) && m_a_valid[i]) begin
                    w_has_win = 1'b1;
                    w_win     = MGR_W'(i);
                end
            end
        end
    end

    always_comb begin
        m_a_ready = '0;
        w_id      = '0;
        w_addr    = '0;
        w_atop    = '0;
        for (int unsigned i = 0; i < NUM_MGR; i++) begin
            if (MGR_W'(i) == w_win) begin
                m_a_ready[i] = w_can_load & w_has_win;
                w_id         = m_a_id[4*i +: 4];
                w_addr       = m_a_addr[32*i +: 32];
                w_atop       = m_a_atop[6*i +: 6];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_accept) w_state_nxt = FULL;
            FULL:    if (s_a_ready && !w_accept) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_last  <= MGR_W'(NUM_MGR - 1);
            r_id    <= '0;
            r_addr  <= '0;
            r_atop  <= '0;
            r_mgr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last <= w_win;
                r_id   <= w_id;
                r_addr <= w_addr;
                r_atop <= w_atop;
                r_mgr  <= w_win;
            end
        end
    end

`ifdef REQ_ARB_STATS_EN
    logic [15:0] r_grant_cnt [NUM_MGR];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_MGR; i++) r_grant_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_MGR; i++) begin
                if (stats_clr)
                    r_grant_cnt[i] <= '0;
                else if (w_accept && (MGR_W'(i) == w_win) && (r_grant_cnt[i] != '1))
                    r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < NUM_MGR; i++) grant_cnt[16*i +: 16] = r_grant_cnt[i];
    end
`endif

endmodule

// File: tb/tb_req_chan_arb.sv
// Directed self-checking bench for req_chan_arb: a vector table plus hand-written multi-cycle sequences.
// Grant-counter checks are compiled only when REQ_ARB_STATS_EN is defined.
module tb_req_chan_arb;

    localparam int NUM_MGR = 4;
    localparam int MGR_W   = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_MGR-1:0]    m_a_valid = '0;
    logic [NUM_MGR-1:0]    m_a_ready;
    logic [4*NUM_MGR-1:0]  m_a_id;
    logic [32*NUM_MGR-1:0] m_a_addr;
    logic [6*NUM_MGR-1:0]  m_a_atop;
    logic                  s_a_valid;
    logic                  s_a_ready = 1'b0;
    logic [3:0]            s_a_id;
    logic [31:0]           s_a_addr;
    logic [5:0]            s_a_atop;
    logic [MGR_W-1:0]      s_a_mgr;
`ifdef REQ_ARB_STATS_EN
    logic                  stats_clr = 1'b0;
    logic [16*NUM_MGR-1:0] grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    req_chan_arb #(.NUM_MGR(NUM_MGR), .MGR_W(MGR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .m_a_valid (m_a_valid),
        .m_a_ready (m_a_ready),
        .m_a_id    (m_a_id),
        .m_a_addr  (m_a_addr),
        .m_a_atop  (m_a_atop),
        .s_a_valid (s_a_valid),
        .s_a_ready (s_a_ready),
        .s_a_id    (s_a_id),
        .s_a_addr  (s_a_addr),
        .s_a_atop  (s_a_atop),
        .s_a_mgr   (s_a_mgr)
`ifdef REQ_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    typedef struct packed {
        logic [3:0] valid;
        logic       rdy;
        logic [3:0] exp_ready;
        logic       exp_sv;
        logic [1:0] exp_mgr;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Manager i always presents id 4i+1, addr 0x1000_0000+0x40*i, atop 0x10+i.
    function automatic logic [3:0] exp_id(input int m);
        return 4'(4 * m + 1);
    endfunction
    function automatic logic [31:0] exp_addr(input int m);
        return 32'h1000_0000 + 32'(32'h40 * m);
    endfunction
    function automatic logic [5:0] exp_atop(input int m);
        return 6'(6'h10 + m);
    endfunction

    task automatic check_held(input string tag, input int m);
        chk({tag, "_valid"}, 64'(s_a_valid), 64'd1);
        chk({tag, "_mgr"},   64'(s_a_mgr),   64'(m));
        chk({tag, "_id"},    64'(s_a_id),    64'(exp_id(m)));
        chk({tag, "_addr"},  64'(s_a_addr),  64'(exp_addr(m)));
        chk({tag, "_atop"},  64'(s_a_atop),  64'(exp_atop(m)));
    endtask

    // Called one time unit after a rising edge; leaves rst low well before the next edge.
    task automatic do_reset();
        m_a_valid = '0;
        s_a_ready = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic cycle(input logic [3:0] v, input logic r);
        @(posedge clk);
        #1;
        m_a_valid = v;
        s_a_ready = r;
        #3;
    endtask

    initial begin
        for (int i = 0; i < NUM_MGR; i++) begin
            m_a_id[4*i +: 4]    = exp_id(i);
            m_a_addr[32*i +: 32] = exp_addr(i);
            m_a_atop[6*i +: 6]  = exp_atop(i);
        end

        //            valid    rdy   exp_ready exp_sv mgr
        vecs[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[1]  = '{4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0};
        vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1};
        vecs[3]  = '{4'b1111, 1'b1, 4'b0100, 1'b0, 2'd0};
        vecs[4]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
        vecs[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
        vecs[7]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3};
        vecs[8]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd0};
        vecs[9]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3};
        vecs[10] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[11] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[13] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
        vecs[14] = '{4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
        vecs[16] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
        vecs[17] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd2};
        vecs[18] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd1};
        vecs[19] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3};
        vecs[20] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
        vecs[21] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

        // Reset values, sampled while rst is held and before any clock edge.
        #2;
        chk("rst_valid", 64'(s_a_valid), 64'd0);
        chk("rst_mgr",   64'(s_a_mgr),   64'd0);
        chk("rst_id",    64'(s_a_id),    64'd0);
        chk("rst_addr",  64'(s_a_addr),  64'd0);
        chk("rst_atop",  64'(s_a_atop),  64'd0);
        chk("rst_ready", 64'(m_a_ready), 64'd0);
        #6;
        rst = 1'b0;

        for (int n = 0; n < 22; n++) begin
            cycle(vecs[n].valid, vecs[n].rdy);
            chk($sformatf("vec%0d_ready", n), 64'(m_a_ready), 64'(vecs[n].exp_ready));
            chk($sformatf("vec%0d_valid", n), 64'(s_a_valid), 64'(vecs[n].exp_sv));
            if (vecs[n].exp_sv) check_held($sformatf("vec%0d", n), int'(vecs[n].exp_mgr));
        end

        // Fairness: all managers valid, grants rotate 0,1,2,3,0,1,2,3 one per cycle.
        @(posedge clk); #1; do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(4'b1111, 1'b1);
            chk($sformatf("rr%0d_ready", k), 64'(m_a_ready), 64'(4'b0001 << (k % 4)));
            chk($sformatf("rr%0d_valid", k), 64'(s_a_valid), 64'(k > 0));
            if (k > 0) chk($sformatf("rr%0d_mgr", k), 64'(s_a_mgr), 64'((k - 1) % 4));
        end
        cycle(4'b0000, 1'b0);
        check_held("rr_last", 3);

        // Backpressure: register holds mgr0 for five stalled cycles while mgr2 waits.
        @(posedge clk); #1; do_reset();
        cycle(4'b0001, 1'b0);
        chk("bp_load_ready", 64'(m_a_ready), 64'(4'b0001));
        for (int k = 0; k < 5; k++) begin
            cycle(4'b0100, 1'b0);
            chk($sformatf("bp%0d_ready", k), 64'(m_a_ready), 64'd0);
            check_held($sformatf("bp%0d", k), 0);
        end
        cycle(4'b0100, 1'b1);
        chk("bp_release_ready", 64'(m_a_ready), 64'(4'b0100));
        check_held("bp_release", 0);
        cycle(4'b0000, 1'b0);
        check_held("bp_after", 2);

        // Asynchronous reset while FULL and stalled, mid-cycle.
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(s_a_valid), 64'd0);
        chk("arst_mgr",   64'(s_a_mgr),   64'd0);
        chk("arst_addr",  64'(s_a_addr),  64'd0);
        #1;
        rst = 1'b0;
        cycle(4'b1111, 1'b1);
        chk("arst_first_ready", 64'(m_a_ready), 64'(4'b0001));
        cycle(4'b0000, 1'b1);
        check_held("arst_first", 0);

`ifdef REQ_ARB_STATS_EN
        // Counter saturation after 70000 accepts from mgr0, then clear racing an increment.
        @(posedge clk); #1; do_reset();
        m_a_valid = 4'b0001;
        s_a_ready = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        chk("stat_sat0", 64'(grant_cnt[15:0]),  64'hFFFF);
        chk("stat_cnt1", 64'(grant_cnt[31:16]), 64'd0);
        chk("stat_cnt3", 64'(grant_cnt[63:48]), 64'd0);
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        chk("stat_clr0", 64'(grant_cnt[15:0]), 64'd0);
        @(posedge clk); #1;
        chk("stat_inc0", 64'(grant_cnt[15:0]), 64'd1);
        m_a_valid = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
